riscv_issue_ctrl: RTL
=====================

# riscv_issue_ctrl

Multi-cycle issue controller for the RiscV R-type integer datapath. It accepts 32-bit instructions over a valid/ready handshake into a small FIFO. It sequences each instruction through decode, execute and writeback, driving the register-file addresses, ALU operation and write-enable of the datapath. It also flags unsupported encodings and counts retired instructions.

## Interface
- DEPTH, 4, instruction FIFO entries; power of two, at least 2
- CNT_W, 16, width of the retired-instruction counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_in  in  32  instruction word
- instr_valid  in  1  instr_in is valid
- instr_ready  out  1  FIFO can accept; equals !full (from the registered count)
- rs1_addr  out  5  register-file read address 1 (instr[19:15])
- rs2_addr  out  5  register-file read address 2 (instr[24:20])
- rd_addr  out  5  register-file write address (instr[11:7])
- alu_op  out  4  ALU operation, encoded as {funct7[5], funct3}
- rf_we  out  1  register-file write enable, one-cycle pulse
- illegal  out  1  one-cycle pulse when the decoded instruction is unsupported
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty
- retired_cnt  out  CNT_W  count of instructions completing WB; wraps modulo 2^CNT_W

## Operation
- FIFO
  - Push on instr_valid && instr_ready.
  - Pop only by the FSM in IDLE when the count is non-zero.
  - Push and pop in the same cycle are both honoured and leave the count unchanged.
  - While full, instr_ready is 0, even if a pop occurs that cycle; no push is accepted.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE: if the FIFO is non-empty, pop the head into the instruction register (IR) and go to DECODE; otherwise stay in IDLE.
  - DECODE, legal encoding: register rs1_addr, rs2_addr, rd_addr and alu_op from IR, then go to EXEC.
  - DECODE, illegal encoding: pulse illegal for one cycle, leave the address and alu_op outputs unchanged, go to IDLE. There is no rf_we and no retire.
  - EXEC: one cycle; outputs are held. Go to WB.
  - WB: rf_we = 1 for this single cycle only if rd_addr != 0. retired_cnt increments by 1 regardless of rd. Go to IDLE.
- Legal encoding requires opcode 7'b0110011 and one of:
  - funct7 = 7'b0000000 with any funct3;
  - funct7 = 7'b0100000 with funct3 000 (SUB) or 101 (SRA).
- Every other encoding is illegal, e.g. M-extension funct7 = 0000001, or a non-R-type opcode.
- alu_op values:
  - ADD 0000, SUB 1000
  - SLL 0001, SLT 0010, SLTU 0011
  - XOR 0100, SRL 0101, SRA 1101
  - OR 0110, AND 0111
- All outputs are registered except instr_ready and busy, which are combinational from registered state.

## Timing
- Reset values:
  - state IDLE, FIFO empty, IR = 0;
  - rs1_addr, rs2_addr, rd_addr, alu_op = 0;
  - rf_we, illegal, busy = 0; retired_cnt = 0;
  - instr_ready = 1.
- Reset takes effect immediately and asynchronously, including mid-instruction. An in-flight instruction is discarded: it produces no rf_we and no count increment.
- Latency, with the instruction accepted at edge E:
  - pop into IR at E+1 (state DECODE);
  - decoded outputs valid after E+2 (state EXEC);
  - rf_we high in the cycle between E+3 and E+4.
- Illegal instructions pulse illegal in the cycle between E+2 and E+3.
- Throughput is one instruction per 4 cycles (IDLE, DECODE, EXEC, WB).
- An IDLE cycle always separates consecutive instructions.
- Back-to-back pushes with a continuously asserted valid:
  - the FIFO first reaches full at the 5th accepted push (DEPTH = 4);
  - instr_ready stays 0 until the next pop.
- retired_cnt wraps from 2^CNT_W-1 to 0 without any flag.

## Test plan
- Push 32'h00b50c33 (add x24,x10,x11) -> rs1 = 10, rs2 = 11, rd = 24, alu_op = 0000; rf_we pulses between E+3 and E+4; retired_cnt = 1.
- Push 32'h40b50c33, then 32'h00b51c33, then 32'h00b52c33 -> alu_op 1000, 0001, 0010 in order; three rf_we pulses 4 cycles apart; retired_cnt = 3.
- Push 32'h02b50c33 (mul) -> illegal pulses once; no rf_we; retired_cnt unchanged. Then push 32'h00b50c33 -> normal retire.
- Push 32'h00b50033 (rd = x0) -> rf_we stays 0; retired_cnt increments by 1.
- Hold instr_valid with 6 distinct adds -> instr_ready is 0 for cycles while full; all 6 retire in push order with matching rd_addr; retired_cnt = 6; busy falls only after the final WB.
- Assert rst during EXEC with 2 entries queued -> all outputs at reset values immediately; no rf_we; after release the FIFO is empty and busy = 0.

Source files
------------

// File: rtl/riscv_issue_ctrl_if.sv
// Handshake and datapath-control bundle for riscv_issue_ctrl.
// The master side supplies instructions; the slave side is the controller.
interface riscv_issue_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [31:0]      instr_in;
  logic             instr_valid;
  logic             instr_ready;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [4:0]       rd_addr;
  logic [3:0]       alu_op;
  logic             rf_we;
  logic             illegal;
  logic             busy;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output instr_in, instr_valid,
    input  instr_ready, rs1_addr, rs2_addr, rd_addr, alu_op, rf_we, illegal, busy, retired_cnt
  );

  modport slave (
    input  instr_in, instr_valid,
    output instr_ready, rs1_addr, rs2_addr, rd_addr, alu_op, rf_we, illegal, busy, retired_cnt
  );
endinterface

// File: rtl/riscv_issue_ctrl.sv
// Multi-cycle issue controller for R-type integer instructions: instruction FIFO
// feeding an IDLE/DECODE/EXEC/WB sequencer with registered datapath controls.
module riscv_issue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  riscv_issue_ctrl_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

  state_e           state_q;
  logic [31:0]      ir_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic [3:0]       alu_op_q;
  logic             rf_we_q, illegal_q;
  logic [CNT_W-1:0] retired_q;

  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full, push, pop;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       legal;

  // Ready comes from the registered count only, so a same-cycle pop never frees a full FIFO.
  assign full = (count_q == FullCnt);
  assign push = bus.instr_valid && !full;
  assign pop  = (state_q == StIdle) && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read behind a non-zero count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.instr_in;
  end

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  always_comb begin
    legal = (opcode == 7'b0110011) &&
            ((funct7 == 7'b0000000) ||
             ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      ir_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      alu_op_q  <= '0;
      rf_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      rf_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            ir_q    <= mem_q[rd_ptr_q];
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (legal) begin
            rs1_q    <= ir_q[19:15];
            rs2_q    <= ir_q[24:20];
            rd_q     <= ir_q[11:7];
            alu_op_q <= {ir_q[30], ir_q[14:12]};
            state_q  <= StExec;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        // Strobes are set on entry to WB so they are visible for exactly the WB cycle.
        StExec: begin
          rf_we_q   <= (rd_q != 5'd0);
          retired_q <= retired_q + 1'b1;
          state_q   <= StWb;
        end
        StWb: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.instr_ready = !full;
  assign bus.busy        = (state_q != StIdle) || (count_q != '0);
  assign bus.rs1_addr    = rs1_q;
  assign bus.rs2_addr    = rs2_q;
  assign bus.rd_addr     = rd_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.illegal     = illegal_q;
  assign bus.retired_cnt = retired_q;

endmodule
